// File: rtl/pea_pkg.sv
// pea_pkg -- shared types and constants for the FU issue controller.
//   fu_instr_t         : FU opcode driven on instr_i (static during a kernel)
//   issue_state_t      : issue FSM states
//   N_BITS             : operand / result datapath width
//   DIV_TIMEOUT_CYCLES : divider watchdog limit (used only with FU_ISSUE_DIV_TIMEOUT_EN)
package pea_pkg;

  localparam int N_BITS             = 32;
  localparam int DIV_TIMEOUT_CYCLES = 64;

  typedef enum logic [3:0] {
    FU_ADD  = 4'd0,
    FU_SUB  = 4'd1,
    FU_MUL  = 4'd2,
    FU_DIV  = 4'd3,
    FU_DIVU = 4'd4,
    FU_ACC  = 4'd5,
    FU_MAX  = 4'd6,
    FU_NOP  = 4'd7
  } fu_instr_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_DIV = 1'b1
  } issue_state_t;

  // Multi-cycle opcodes: the FU returns fu_valid_i some cycles after issue.
  function automatic logic is_div(input fu_instr_t op);
    return (op == FU_DIV) || (op == FU_DIVU);
  endfunction

  // Opcodes whose result is kept in the accumulator for loopback.
  function automatic logic is_acc(input fu_instr_t op);
    return (op == FU_ACC) || (op == FU_MAX);
  endfunction

endpackage

// File: rtl/fu_result_slot.sv
// fu_result_slot -- one-entry valid/ready result register.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   in_valid_i, in_data_i : capture strobe and data (caller guarantees in_ready_o)
//   in_ready_o            : slot empty or being drained this cycle
//   out_valid_o/data_o    : held result, stable until out_ready_i
//   out_ready_i           : downstream accepts the result
module fu_result_slot
  import pea_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [N_BITS-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [N_BITS-1:0] out_data_o,
  input  logic              out_ready_i
);

  logic              full_q, full_d;
  logic [N_BITS-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    // Capture wins over drain, so a simultaneous drain+capture keeps valid high.
    if (in_valid_i) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (out_ready_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready_o  = ~full_q | out_ready_i;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl -- operand slot, issue FSM and result buffer in front of a FU.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   instr_i                   : FU opcode (static per kernel)
//   reg_acc_value_i           : accumulation length, forwarded on fu_acc_value_o
//   in_a_i/in_b_i/in_valid_i  : upstream operand pair; in_ready_o accepts it
//   fu_a_o/fu_b_o             : operands to FU; b replaced by acc_q on loopback
//   fu_ops_valid_o            : issue strobe; fu_ready_i FU can accept
//   fu_valid_i/fu_res_i       : FU result; fu_acc_loopback_i selects acc on b
//   out_data_o/out_valid_o    : buffered result; out_ready_i downstream accept
//   err_o                     : sticky divider timeout (only with FU_ISSUE_DIV_TIMEOUT_EN)
// Optional feature macro: FU_ISSUE_DIV_TIMEOUT_EN adds the divider watchdog.
module fu_issue_ctrl
  import pea_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  fu_instr_t         instr_i,
  input  logic [7:0]        reg_acc_value_i,
  output logic [7:0]        fu_acc_value_o,
  input  logic [N_BITS-1:0] in_a_i,
  input  logic [N_BITS-1:0] in_b_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [N_BITS-1:0] fu_a_o,
  output logic [N_BITS-1:0] fu_b_o,
  output logic              fu_ops_valid_o,
  input  logic              fu_ready_i,
  input  logic              fu_valid_i,
  input  logic [N_BITS-1:0] fu_res_i,
  input  logic              fu_acc_loopback_i,
`ifdef FU_ISSUE_DIV_TIMEOUT_EN
  output logic              err_o,
`endif
  output logic [N_BITS-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  issue_state_t      state_q, state_d;
  logic              slot_full_q, slot_full_d;
  logic [N_BITS-1:0] slot_a_q, slot_a_d;
  logic [N_BITS-1:0] slot_b_q, slot_b_d;
  logic [N_BITS-1:0] acc_q, acc_d;
  fu_instr_t         instr_q, instr_d;

  logic issue;
  logic in_fire;
  logic res_capture;
  logic res_in_ready;

`ifdef FU_ISSUE_DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(DIV_TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_q, err_d;
  logic             timeout;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (issue && is_div(instr_i)) state_d = WAIT_DIV;
      WAIT_DIV: begin
        if (fu_valid_i) state_d = IDLE;
`ifdef FU_ISSUE_DIV_TIMEOUT_EN
        else if (timeout) state_d = IDLE;
`endif
      end
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    // Issue only if the result slot is guaranteed a free entry when the
    // combinational FU answers in the same cycle.
    issue = slot_full_q & fu_ready_i & (state_q == IDLE) & res_in_ready;
    // Results are accepted only when one is owed: same-cycle for non-DIV
    // issues, or the awaited divider completion. Stray valids are dropped.
    res_capture = fu_valid_i &
                  ((state_q == WAIT_DIV) | (issue & ~is_div(instr_i)));
`ifdef FU_ISSUE_DIV_TIMEOUT_EN
    // Completion on the last allowed cycle still counts as a success.
    timeout = (state_q == WAIT_DIV) & ~fu_valid_i &
              (tmo_cnt_q == CNT_W'(DIV_TIMEOUT_CYCLES - 1));
`endif
  end

  // ---------------- operand slot / accumulator ----------------
  always_comb begin
    in_ready_o  = ~slot_full_q | issue;
    in_fire     = in_valid_i & in_ready_o;
    slot_full_d = slot_full_q;
    slot_a_d    = slot_a_q;
    slot_b_d    = slot_b_q;
    if (in_fire) begin
      slot_full_d = 1'b1;
      slot_a_d    = in_a_i;
      slot_b_d    = in_b_i;
    end else if (issue) begin
      slot_full_d = 1'b0;
    end

    instr_d = instr_i;
    acc_d   = acc_q;
    // An opcode change starts a new kernel: drop the stale accumulator.
    if (instr_i != instr_q)  acc_d = '0;
    else if (issue)          acc_d = is_acc(instr_i) ? fu_res_i : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_full_q <= 1'b0;
      slot_a_q    <= '0;
      slot_b_q    <= '0;
      acc_q       <= '0;
      instr_q     <= FU_ADD;
    end else begin
      slot_full_q <= slot_full_d;
      slot_a_q    <= slot_a_d;
      slot_b_q    <= slot_b_d;
      acc_q       <= acc_d;
      instr_q     <= instr_d;
    end
  end

`ifdef FU_ISSUE_DIV_TIMEOUT_EN
  // ---------------- divider watchdog ----------------
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == WAIT_DIV) && (state_d == WAIT_DIV)) tmo_cnt_d = tmo_cnt_q + 1'b1;
    err_d = err_q | timeout;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`endif

  // ---------------- FU interface ----------------
  assign fu_ops_valid_o = issue;
  assign fu_a_o         = slot_a_q;
  assign fu_b_o         = fu_acc_loopback_i ? acc_q : slot_b_q;
  assign fu_acc_value_o = reg_acc_value_i;

  fu_result_slot u_res_slot (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (res_capture),
    .in_data_i   (fu_res_i),
    .in_ready_o  (res_in_ready),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i)
  );

endmodule
